// File: rtl/watch_pkg.sv
// Shared definitions for the watch controller: mode encodings,
// time-field widths and wrap limits.
package watch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int HOUR_LIM = 24;
  localparam int MIN_LIM  = 60;
  localparam int SEC_LIM  = 60;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-LIMIT counter; wrap flags the increment that rolls over to 0.
// Knows nothing about modes: the caller decides when to increment.
module wrap_counter #(
  parameter int LIMIT = 60,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT - 1);

  assign wrap = inc && (value == MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// Watch controller: run/set mode FSM plus hh:mm:ss carry chain.
// Optional WATCH_CTRL_DAY_CARRY_EN adds the o_day_tick output.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int P_COUNT_BIT = 30,
  parameter int P_FREQ      = 100_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_tick,
  input  logic                   i_btn_mode,
  input  logic                   i_btn_inc,
  output logic                   o_run_en,
  output logic [P_COUNT_BIT-1:0] o_freq,
  output logic [HOUR_W-1:0]      o_hour,
  output logic [MIN_W-1:0]       o_min,
  output logic [SEC_W-1:0]       o_sec,
  output logic [1:0]             o_mode
`ifdef WATCH_CTRL_DAY_CARRY_EN
  ,
  output logic                   o_day_tick
`endif
);

  mode_t state, state_nx;
  logic  run_tick, set_inc;
  logic  sec_inc, min_inc, hour_inc;
  logic  sec_wrap, min_wrap;

  assign o_freq = P_COUNT_BIT'(P_FREQ);
  assign o_mode = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      o_run_en <= 1'b1;
    end else begin
      state    <= state_nx;
      o_run_en <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx = state;
    if (i_btn_mode) begin
      unique case (state)
        RUN:      state_nx = SET_HOUR;
        SET_HOUR: state_nx = SET_MIN;
        SET_MIN:  state_nx = SET_SEC;
        SET_SEC:  state_nx = RUN;
      endcase
    end
  end

  // A mode press wins over a simultaneous increment.
  assign run_tick = (state == RUN) && i_tick;
  assign set_inc  = i_btn_inc && !i_btn_mode;

  assign sec_inc  = run_tick
                 || (state == SET_SEC && set_inc);
  assign min_inc  = (run_tick && sec_wrap)
                 || (state == SET_MIN && set_inc);
  assign hour_inc = (run_tick && sec_wrap && min_wrap)
                 || (state == SET_HOUR && set_inc);

  wrap_counter #(.LIMIT(SEC_LIM), .WIDTH(SEC_W)) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .value (o_sec),
    .wrap  (sec_wrap)
  );

  wrap_counter #(.LIMIT(MIN_LIM), .WIDTH(MIN_W)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .value (o_min),
    .wrap  (min_wrap)
  );

`ifdef WATCH_CTRL_DAY_CARRY_EN
  logic hour_wrap;

  wrap_counter #(.LIMIT(HOUR_LIM), .WIDTH(HOUR_W)) u_hour (
    .clk   (clk),
    .reset (reset),
    .inc   (hour_inc),
    .value (o_hour),
    .wrap  (hour_wrap)
  );

  // Only a clock-driven rollover counts as a new day.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_day_tick <= 1'b0;
    end else begin
      o_day_tick <= run_tick && hour_wrap;
    end
  end
`else
  logic unused_hour_wrap;

  wrap_counter #(.LIMIT(HOUR_LIM), .WIDTH(HOUR_W)) u_hour (
    .clk   (clk),
    .reset (reset),
    .inc   (hour_inc),
    .value (o_hour),
    .wrap  (unused_hour_wrap)
  );
`endif

endmodule

// File: doc/watch_ctrl.md
WATCH_CTRL -- requirements
Module: watch_ctrl

Interface
REQ-001 SHALL have parameter P_COUNT_BIT, default 30, width of the tick-generator frequency word.
REQ-002 SHALL have parameter P_FREQ, default 100_000_000, clock frequency in Hz driven to the tick generator.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_tick  input  1  one-second pulse from the tick generator.
REQ-006 SHALL have port i_btn_mode  input  1  debounced single-cycle mode-advance pulse.
REQ-007 SHALL have port i_btn_inc  input  1  debounced single-cycle increment pulse.
REQ-008 SHALL have port o_run_en  output  1  run enable to the tick generator.
REQ-009 SHALL have port o_freq  output  P_COUNT_BIT  frequency word to the tick generator, constant P_FREQ.
REQ-010 SHALL have ports o_hour/o_min/o_sec  output  5/6/6  current time, binary.
REQ-011 SHALL have port o_mode  output  2  current FSM state encoding.

Function
REQ-012 SHALL implement FSM states RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
REQ-013 SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN on each i_btn_mode pulse, one state per pulse.
REQ-014 SHALL drive o_run_en registered: 1 in RUN, 0 in all SET states, changing on the same edge as the state.
REQ-015 SHALL, in RUN on i_tick, increment sec; sec 59->0 carries min+1; min 59->0 carries hour+1; hour 23->0; outputs update one cycle after i_tick.
REQ-016 SHALL ignore i_tick in all SET states.
REQ-017 SHALL, in SET_x on i_btn_inc, increment only the selected field modulo its limit (24/60/60) with no carry into other fields.
REQ-018 SHALL, on entering SET_SEC, leave sec unchanged; on SET_SEC->RUN transition, clear nothing (time resumes from set value).
REQ-019 SHALL, on simultaneous i_tick and i_btn_mode in RUN, apply the tick increment and the transition to SET_HOUR on the same edge.
REQ-020 SHALL, on simultaneous i_btn_mode and i_btn_inc in a SET state, take the transition and discard the increment.
REQ-021 SHALL ignore i_btn_inc in RUN.
REQ-022 SHALL drive o_freq = P_FREQ truncated to P_COUNT_BIT at all times.

Reset
REQ-023 SHALL, while reset is low, force state RUN, o_hour=o_min=o_sec=0, o_run_en=1, o_mode=0 asynchronously.
REQ-024 SHALL, on reset assertion mid-SET, abandon the partial setting and return to RUN with time 00:00:00.

Configuration
REQ-025 SHALL, with WATCH_CTRL_DAY_CARRY_EN defined, add output o_day_tick (1 bit, reset 0), pulsing high one cycle when time wraps 23:59:59->00:00:00 in RUN only.
REQ-026 SHALL, without WATCH_CTRL_DAY_CARRY_EN, omit o_day_tick and its logic; all other behaviour identical.
REQ-027 SHALL NOT pulse o_day_tick when hour wraps 23->0 via i_btn_inc in SET_HOUR.

Structure
REQ-028 SHALL place the state encodings, field widths and limits (24, 60) in shared package watch_pkg.
REQ-029 SHALL instantiate three copies of sub-module wrap_counter (parameter LIMIT; inputs inc; outputs value, wrap) for hour/min/sec.
REQ-030 SHALL keep the FSM and carry chain in watch_ctrl; wrap_counter contains no mode knowledge.

Verification
REQ-031 SHALL check: reset released, 3 i_tick pulses in RUN -> o_sec=3, o_run_en=1, o_mode=0.
REQ-032 SHALL check: time 23:59:59, i_tick -> 00:00:00 next cycle; o_day_tick=1 for one cycle when macro defined.
REQ-033 SHALL check: mode x1, inc x25 -> o_hour=1, o_run_en=0, o_min/o_sec unchanged; i_tick pulses meanwhile -> no change.
REQ-034 SHALL check: SET_MIN at 59, inc -> o_min=0, o_hour unchanged; mode+inc same cycle -> SET_SEC, o_sec unchanged.
REQ-035 SHALL check: RUN at 00:00:10, i_tick and i_btn_mode same cycle -> o_sec=11, o_mode=1, o_run_en=0.
REQ-036 SHALL check: reset low in SET_MIN after edits -> immediately o_mode=0, 00:00:00, o_run_en=1 without clock edge.
